// File: rtl/div_pipe_stream.sv
// div_pipe_stream: streaming unsigned integer divider, one restoring-division step per
// pipeline stage, with valid/ready handshakes on both sides.
//
// Optional feature macro: DIV_PIPE_ROUND_EN. When it is defined, one extra output stage
// rounds the quotient half up (saturating at all ones), and latency and capacity both
// become NUMER_W+1.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   snk_valid  operand pair valid           snk_ready  pipeline can accept this cycle
//   snk_numer  dividend [NUMER_W]           snk_denom  divisor [DENOM_W]
//   snk_tag    sideband tag [TAG_W]
//   src_valid  result valid                 src_ready  downstream accepts
//   src_quot   quotient [NUMER_W]           src_rem    remainder [DENOM_W]
//   src_dz     divisor was zero             src_tag    tag of the source operands
//
// Each stage has its own valid bit, so bubbles collapse under backpressure. A stage
// accepts when any stage at or below it, toward the output, is empty, or when src_ready
// is high. That rule is computed in closed form, so snk_ready depends only on the stage
// valids and src_ready. It never depends on snk_valid.

// One restoring step: shift in the numerator MSB, then subtract the divisor if it fits.
module div_stage #(
  parameter int NUMER_W = 32,
  parameter int DENOM_W = 16,
  parameter int TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DENOM_W:0]   r_in,
  input  logic [NUMER_W-1:0] nq_in,
  input  logic [DENOM_W-1:0] d_in,
  input  logic               dz_in,
  input  logic [TAG_W-1:0]   tag_in,
  output logic [DENOM_W:0]   r_out,
  output logic [NUMER_W-1:0] nq_out,
  output logic [DENOM_W-1:0] d_out,
  output logic               dz_out,
  output logic [TAG_W-1:0]   tag_out
);
  logic [DENOM_W:0] r_sh, r_sub;
  logic             q_bit;

  // For a nonzero divisor, r_in < d_in, so bit DENOM_W of r_in is zero and dropping it
  // is safe. For a zero divisor, the remainder simply accumulates the numerator's low bits.
  assign r_sh  = {r_in[DENOM_W-1:0], nq_in[NUMER_W-1]};
  assign q_bit = (r_sh >= {1'b0, d_in});
  assign r_sub = r_sh - {1'b0, d_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out   <= '0;
      nq_out  <= '0;
      d_out   <= '0;
      dz_out  <= 1'b0;
      tag_out <= '0;
    end else if (load) begin
      r_out   <= q_bit ? r_sub : r_sh;
      // Numerator bits shift out of the top while quotient bits shift in at the bottom.
      nq_out  <= (nq_in << 1) | NUMER_W'(q_bit);
      d_out   <= d_in;
      dz_out  <= dz_in;
      tag_out <= tag_in;
    end
  end
endmodule

module div_pipe_stream #(
  parameter int NUMER_W = 32,
  parameter int DENOM_W = 16,
  parameter int TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               snk_valid,
  input  logic [NUMER_W-1:0] snk_numer,
  input  logic [DENOM_W-1:0] snk_denom,
  input  logic [TAG_W-1:0]   snk_tag,
  output logic               snk_ready,
  output logic               src_valid,
  output logic [NUMER_W-1:0] src_quot,
  output logic [DENOM_W-1:0] src_rem,
  output logic               src_dz,
  output logic [TAG_W-1:0]   src_tag,
  input  logic               src_ready
);
`ifdef DIV_PIPE_ROUND_EN
  localparam int STAGES = NUMER_W + 1;
`else
  localparam int STAGES = NUMER_W;
`endif

  logic [STAGES-1:0] vld_pipe, rdy, in_vld;
  logic              full_above;

  logic [NUMER_W-1:0][DENOM_W:0]   r_st;
  logic [NUMER_W-1:0][NUMER_W-1:0] nq_st;
  logic [NUMER_W-1:0][DENOM_W-1:0] d_st;
  logic [NUMER_W-1:0]              dz_st;
  logic [NUMER_W-1:0][TAG_W-1:0]   tag_st;

  // Stage k can take a beat unless it and every stage after it are full while the
  // output is stalled.
  always_comb begin
    full_above = 1'b1;
    rdy        = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full_above = full_above & vld_pipe[k];
      rdy[k]     = src_ready | ~full_above;
    end
  end

  always_comb begin
    in_vld    = '0;
    in_vld[0] = snk_valid;
    for (int k = 1; k < STAGES; k++) in_vld[k] = vld_pipe[k-1];
  end

  assign snk_ready = rdy[0];
  assign src_valid = vld_pipe[STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_pipe <= '0;
    else begin
      for (int k = 0; k < STAGES; k++)
        if (rdy[k]) vld_pipe[k] <= in_vld[k];
    end
  end

  for (genvar k = 0; k < NUMER_W; k++) begin : g_stage
    logic [DENOM_W:0]   r_in;
    logic [NUMER_W-1:0] nq_in;
    logic [DENOM_W-1:0] d_in;
    logic               dz_in;
    logic [TAG_W-1:0]   tag_in;

    if (k == 0) begin : g_head
      assign r_in   = '0;
      assign nq_in  = snk_numer;
      assign d_in   = snk_denom;
      assign dz_in  = (snk_denom == '0);
      assign tag_in = snk_tag;
    end else begin : g_body
      assign r_in   = r_st[k-1];
      assign nq_in  = nq_st[k-1];
      assign d_in   = d_st[k-1];
      assign dz_in  = dz_st[k-1];
      assign tag_in = tag_st[k-1];
    end

    div_stage #(.NUMER_W(NUMER_W), .DENOM_W(DENOM_W), .TAG_W(TAG_W)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .load   (rdy[k] & in_vld[k]),
      .r_in   (r_in),
      .nq_in  (nq_in),
      .d_in   (d_in),
      .dz_in  (dz_in),
      .tag_in (tag_in),
      .r_out  (r_st[k]),
      .nq_out (nq_st[k]),
      .d_out  (d_st[k]),
      .dz_out (dz_st[k]),
      .tag_out(tag_st[k])
    );
  end

`ifdef DIV_PIPE_ROUND_EN
  localparam int L = NUMER_W - 1;
  logic [NUMER_W-1:0] rq_q;
  logic [DENOM_W-1:0] rr_q;
  logic               rdz_q;
  logic [TAG_W-1:0]   rtag_q;
  logic               rnd_up;
  logic               tail_unused;

  // Round half up: 2*rem >= denom. Skip the increment when the quotient is already all
  // ones, which covers saturation and also every divide-by-zero result.
  assign rnd_up = !dz_st[L] && ({r_st[L][DENOM_W-1:0], 1'b0} >= {1'b0, d_st[L]})
                  && (nq_st[L] != '1);
  assign tail_unused = r_st[L][DENOM_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rq_q   <= '0;
      rr_q   <= '0;
      rdz_q  <= 1'b0;
      rtag_q <= '0;
    end else if (rdy[STAGES-1] & in_vld[STAGES-1]) begin
      rq_q   <= nq_st[L] + NUMER_W'(rnd_up);
      rr_q   <= r_st[L][DENOM_W-1:0];
      rdz_q  <= dz_st[L];
      rtag_q <= tag_st[L];
    end
  end

  assign src_quot = rq_q;
  assign src_rem  = rr_q;
  assign src_dz   = rdz_q;
  assign src_tag  = rtag_q;
`else
  logic tail_unused;

  // The last stage's divisor copy and the remainder's guard bit have no consumer.
  assign tail_unused = ^{d_st[NUMER_W-1], r_st[NUMER_W-1][DENOM_W]};

  assign src_quot = nq_st[NUMER_W-1];
  assign src_rem  = r_st[NUMER_W-1][DENOM_W-1:0];
  assign src_dz   = dz_st[NUMER_W-1];
  assign src_tag  = tag_st[NUMER_W-1];
`endif
endmodule

// File: tb/tb_div_pipe_stream.sv
// Testbench for div_pipe_stream at its default parameters (32/16/8). It combines
// directed vectors that carry hand-computed results with a scoreboard that checks
// every emitted beat. It also honours DIV_PIPE_ROUND_EN when that macro is defined.
module tb_div_pipe_stream;
  localparam int NW = 32;
  localparam int DW = 16;
  localparam int TW = 8;
`ifdef DIV_PIPE_ROUND_EN
  localparam int LAT = NW + 1;
`else
  localparam int LAT = NW;
`endif

  logic          clk, rst;
  logic          snk_valid, snk_ready, src_valid, src_dz, src_ready;
  logic [NW-1:0] snk_numer, src_quot;
  logic [DW-1:0] snk_denom, src_rem;
  logic [TW-1:0] snk_tag, src_tag;

  div_pipe_stream #(.NUMER_W(NW), .DENOM_W(DW), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .snk_valid(snk_valid),
    .snk_numer(snk_numer),
    .snk_denom(snk_denom),
    .snk_tag  (snk_tag),
    .snk_ready(snk_ready),
    .src_valid(src_valid),
    .src_quot (src_quot),
    .src_rem  (src_rem),
    .src_dz   (src_dz),
    .src_tag  (src_tag),
    .src_ready(src_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
    logic [TW-1:0] t;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   out_cnt  = 0;
  int   mark     = -1;
  int   mark_cyc = 0;
  int   last_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [NW-1:0] n, input logic [DW-1:0] d,
                                 input logic [TW-1:0] t);
    exp_t e;
    e.t  = t;
    e.dz = (d == '0);
    if (d == '0) begin
      e.q = '1;
      e.r = n[DW-1:0];
    end else begin
      e.q = n / NW'(d);
      e.r = DW'(n % NW'(d));
    end
`ifdef DIV_PIPE_ROUND_EN
    if (d != '0 && ({e.r, 1'b0} >= {1'b0, d}) && e.q != '1) e.q = e.q + 1;
`endif
    return e;
  endfunction

  // Scoreboard: every handshake is observed half a cycle before the edge that commits it.
  always @(negedge clk) begin
    if (rst) begin
      if (snk_valid && snk_ready) exp_q.push_back(model(snk_numer, snk_denom, snk_tag));
      if (src_valid && src_ready) begin
        if (exp_q.size() == 0) chk("sb_extra", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("sb_quot", src_quot, mon_e.q);
          chk("sb_rem",  src_rem,  mon_e.r);
          chk("sb_dz",   src_dz,   mon_e.dz);
          chk("sb_tag",  src_tag,  mon_e.t);
        end
        if (out_cnt == mark) mark_cyc = cyc;
        out_cnt++;
        last_cyc = cyc;
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic send(input logic [NW-1:0] n, input logic [DW-1:0] d, input logic [TW-1:0] t);
    bit a;
    int w;
    a = 1'b0;
    w = 0;
    snk_valid = 1'b1;
    snk_numer = n;
    snk_denom = d;
    snk_tag   = t;
    do begin
      @(negedge clk);
      a = snk_ready;
      @(posedge clk);
      #1;
      w++;
    end while (!a && w < 200);
    if (!a) chk("send_timeout", 0, 1);
    snk_valid = 1'b0;
  endtask

  // Counts negedges until src_valid is seen. Returns at that negedge.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!src_valid && n < 200);
    if (!src_valid) chk("wait_timeout", 0, 1);
  endtask

  task automatic drain(input int bound);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < bound) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic run1(input logic [NW-1:0] n, input logic [DW-1:0] d, input logic [TW-1:0] t,
                      input logic [NW-1:0] eq, input logic [DW-1:0] er, input logic edz);
    int lat;
    send(n, d, t);
    wait_out(lat);
    chk("latency", lat, LAT);
    chk("quot", src_quot, eq);
    chk("rem",  src_rem,  er);
    chk("dz",   src_dz,   edz);
    chk("tag",  src_tag,  t);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, start, acc, cnt;
    bit a, snap_ok;
    logic [NW-1:0] snap_q;
    logic [TW-1:0] snap_t;

    rst = 1'b0;
    snk_valid = 1'b0;
    snk_numer = '0;
    snk_denom = '0;
    snk_tag   = '0;
    src_ready = 1'b1;
    #2;
    chk("rst_src_valid", src_valid, 0);
    chk("rst_quot",      src_quot,  0);
    chk("rst_rem",       src_rem,   0);
    chk("rst_dz",        src_dz,    0);
    chk("rst_tag",       src_tag,   0);
    chk("rst_snk_ready", snk_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // 1000/7 = 142 r6; rounding gives 143 because 12 >= 7.
`ifdef DIV_PIPE_ROUND_EN
    run1(32'd1000, 16'd7, 8'h5A, 32'd143, 16'd6, 1'b0);
`else
    run1(32'd1000, 16'd7, 8'h5A, 32'd142, 16'd6, 1'b0);
`endif
    run1(32'h1234_5678, 16'd0, 8'hD2, 32'hFFFF_FFFF, 16'h5678, 1'b1);

    // Back-to-back: 64 beats, one per cycle.
    base  = out_cnt;
    mark  = out_cnt;
    start = cyc;
    for (int i = 0; i < 64; i++) begin
      logic [NW-1:0] n;
      logic [DW-1:0] d;
      n = $urandom;
      d = (i % 9 == 0) ? 16'd0 : ((i % 3 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom));
      send(n, d, 8'(i));
    end
    drain(200);
    chk("b2b_count", out_cnt - base, 64);
    chk("b2b_first", mark_cyc - start, LAT);
    chk("b2b_span",  last_cyc - mark_cyc, 63);
    mark = -1;

    // Backpressure: 40 cycles of stalled output while offering a beat every cycle.
    src_ready = 1'b0;
    acc = 0;
    snap_ok = 1'b0;
    snap_q = '0;
    snap_t = '0;
    for (int i = 0; i < 40; i++) begin
      snk_valid = 1'b1;
      snk_numer = 32'd5000 + 32'(acc * 37);
      snk_denom = 16'(acc + 3);
      snk_tag   = 8'(8'h80 + acc);
      @(negedge clk);
      a = snk_ready;
      if (src_valid && !snap_ok) begin
        snap_ok = 1'b1;
        snap_q  = src_quot;
        snap_t  = src_tag;
      end
      @(posedge clk);
      #1;
      if (a) acc++;
    end
    snk_valid = 1'b0;
    chk("bp_accepted",  acc, LAT);
    chk("bp_snk_ready", snk_ready, 0);
    chk("bp_src_valid", src_valid, 1);
    chk("bp_seen",      snap_ok, 1);
    chk("bp_quot_hold", src_quot, snap_q);
    chk("bp_tag_hold",  src_tag,  snap_t);
    chk("bp_head_tag",  src_tag,  8'h80);
    base = out_cnt;
    src_ready = 1'b1;
    drain(200);
    chk("bp_out_count", out_cnt - base, LAT);

    // Reset mid-flight with a stalled beat sitting at the output.
    src_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(32'd777 + 32'(i), 16'd5, 8'(8'h40 + i));
    repeat (LAT) @(posedge clk);
    #1;
    chk("mid_pre_valid", src_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_valid_drop", src_valid, 0);
    chk("mid_tag_clear",  src_tag,   0);
    chk("mid_snk_ready",  snk_ready, 1);
    exp_q.delete();
    src_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      if (src_valid) cnt++;
    end
    chk("mid_stale", cnt, 0);
    @(posedge clk);
    #1;
    run1(32'd100, 16'd10, 8'h33, 32'd10, 16'd0, 1'b0);

`ifdef DIV_PIPE_ROUND_EN
    run1(32'd11, 16'd4, 8'h01, 32'd3, 16'd3, 1'b0);
    run1(32'd9,  16'd4, 8'h02, 32'd2, 16'd1, 1'b0);
    run1(32'hFFFF_FFFF, 16'd1, 8'h03, 32'hFFFF_FFFF, 16'd0, 1'b0);
`else
    run1(32'd11, 16'd4, 8'h01, 32'd2, 16'd3, 1'b0);
    run1(32'hFFFF_FFFF, 16'hFFFF, 8'h04, 32'h0001_0001, 16'd0, 1'b0);
`endif
    drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
